// File: rtl/miner_pkg.sv
// Shared constants and types for the miner work path.
// Frame geometry and the bit-receiver state encoding live here.
package miner_pkg;

    localparam int WORK_BYTES = 44;
    localparam int MIDSTATE_W = 256;
    localparam int DATA_W     = 96;
    localparam int FRAME_W    = 352;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, mid-bit sampling divider and bit FSM.
// Strobes are combinational on the stop-bit sample so the parent can register them.
module uart_rx_byte
    import miner_pkg::*;
#(
    parameter int DIV  = 434,
    parameter int HALF = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] byte_o,
    output logic       byte_stb_o,
    output logic       stop_err_o,
    output logic       idle_o
);

    localparam int CW = $clog2(DIV);

    logic            sync0_reg, sync1_reg, prev_reg;
    rx_state_t       state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      bit_reg, bit_next;
    logic [7:0]      shift_reg, shift_next;
    logic            fall;

    assign fall = prev_reg & ~sync1_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_reg <= 1'b1;
            sync1_reg <= 1'b1;
            prev_reg  <= 1'b1;
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
        end else begin
            sync0_reg <= rxd;
            sync1_reg <= sync0_reg;
            prev_reg  <= sync1_reg;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        byte_stb_o = 1'b0;
        stop_err_o = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (fall) begin
                    state_next = START;
                    cnt_next   = CW'(HALF - 1);
                end
            end
            START: begin
                if (cnt_reg == '0) begin
                    // A line back high at mid-start is a glitch, not a byte.
                    if (sync1_reg) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        cnt_next   = CW'(DIV - 1);
                        bit_next   = '0;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DATA: begin
                if (cnt_reg == '0) begin
                    shift_next = {sync1_reg, shift_reg[7:1]};
                    cnt_next   = CW'(DIV - 1);
                    if (bit_reg == 3'd7) state_next = STOP;
                    else                 bit_next   = bit_reg + 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            STOP: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                    byte_stb_o = sync1_reg;
                    stop_err_o = ~sync1_reg;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign byte_o = shift_reg;
    assign idle_o = (state_reg == IDLE);

endmodule

// File: rtl/uart_work_rx.sv
// Work receiver: packs 44 UART bytes into midstate + data tail for the hashing core.
// Partial frames are dropped on a bad stop bit or after a long inter-byte gap.
module uart_work_rx
    import miner_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int GAP_CYCLES = 5_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rxd,
    output logic [MIDSTATE_W-1:0] midstate_o,
    output logic [DATA_W-1:0]     data_o,
    output logic                  work_valid_o,
    output logic                  frame_err_o,
    output logic                  busy_o
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int GW   = $clog2(GAP_CYCLES + 1);

    logic [7:0]         rx_byte;
    logic               byte_stb, stop_err, rx_idle;
    logic [FRAME_W-1:0] frame_reg, frame_shift;
    logic [5:0]         count_reg;
    logic [GW-1:0]      gap_reg;
    logic               gap_expire;

    uart_rx_byte #(.DIV(DIV), .HALF(HALF)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .byte_o     (rx_byte),
        .byte_stb_o (byte_stb),
        .stop_err_o (stop_err),
        .idle_o     (rx_idle)
    );

    assign frame_shift = {frame_reg[FRAME_W-9:0], rx_byte};
    assign gap_expire  = rx_idle && (count_reg != '0) && (gap_reg == GW'(GAP_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_reg    <= '0;
            count_reg    <= '0;
            gap_reg      <= '0;
            midstate_o   <= '0;
            data_o       <= '0;
            work_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            work_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            // Byte acceptance has priority over the gap timeout.
            if (byte_stb) begin
                frame_reg <= frame_shift;
                if (count_reg == 6'(WORK_BYTES - 1)) begin
                    midstate_o   <= frame_shift[FRAME_W-1:DATA_W];
                    data_o       <= frame_shift[DATA_W-1:0];
                    work_valid_o <= 1'b1;
                    count_reg    <= '0;
                end else begin
                    count_reg <= count_reg + 1'b1;
                end
            end else if (stop_err) begin
                frame_err_o <= 1'b1;
                count_reg   <= '0;
            end else if (gap_expire) begin
                count_reg <= '0;
            end

            // Timer runs only while waiting between bytes of a partial frame.
            if (!rx_idle || count_reg == '0 || gap_expire) gap_reg <= '0;
            else                                          gap_reg <= gap_reg + 1'b1;
        end
    end

    assign busy_o = (count_reg != '0);

endmodule

// File: tb/tb_uart_work_rx.sv
// Randomised bench for uart_work_rx against a byte-queue model of frame assembly.
// Runs at a reduced baud divider so full frames stay short.
module tb_uart_work_rx;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int GAP    = 200;
    localparam int DIV    = CLK_HZ / BAUD;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rxd = 1'b1;
    logic [255:0] midstate_o;
    logic [95:0]  data_o;
    logic         work_valid_o, frame_err_o, busy_o;

    uart_work_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .GAP_CYCLES(GAP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rxd          (rxd),
        .midstate_o   (midstate_o),
        .data_o       (data_o),
        .work_valid_o (work_valid_o),
        .frame_err_o  (frame_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Monitor: counts pulses and flags pulses longer than one cycle.
    int          cyc = 0;
    int          valid_cnt = 0, err_cnt = 0, wide_cnt = 0;
    int          last_valid_cyc = 0, prev_valid_cyc = 0;
    logic        valid_d = 1'b0, err_d = 1'b0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        valid_d <= work_valid_o;
        err_d   <= frame_err_o;
        if (rst_n) begin
            if (work_valid_o) begin
                valid_cnt      <= valid_cnt + 1;
                prev_valid_cyc <= last_valid_cyc;
                last_valid_cyc <= cyc;
            end
            if (frame_err_o) err_cnt <= err_cnt + 1;
            if ((work_valid_o && valid_d) || (frame_err_o && err_d)) wide_cnt <= wide_cnt + 1;
        end
    end

    // Reference model: bytes accepted so far, expected outputs and pulse counts.
    logic [7:0]   q[$];
    logic [255:0] exp_ms = '0;
    logic [95:0]  exp_data = '0;
    int           exp_valid = 0, exp_err = 0;

    task automatic check(input string tag, input logic [351:0] got, input logic [351:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_accept(input logic [7:0] b);
        q.push_back(b);
        if (q.size() == 44) begin
            for (int i = 0; i < 32; i++) exp_ms   = {exp_ms[247:0], q[i]};
            for (int i = 32; i < 44; i++) exp_data = {exp_data[87:0], q[i]};
            exp_valid++;
            q.delete();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int idle);
        rxd = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(DIV);
        end
        rxd = stop;
        tick(DIV);
        rxd = 1'b1;
        if (stop) model_accept(b);
        else begin
            exp_err++;
            q.delete();
        end
        tick(idle);
        check("busy_per_byte", 352'(busy_o), 352'(q.size() != 0));
    endtask

    task automatic send_frame(input int kind, input int max_idle);
        for (int i = 0; i < 44; i++) begin
            logic [7:0] b;
            case (kind)
                0:       b = 8'(i);
                1:       b = 8'hA5;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send_byte(b, 1'b1, (max_idle == 0) ? 0 : $urandom_range(0, max_idle));
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_ms"}, 352'(midstate_o), 352'(exp_ms));
        check({tag, "_data"}, 352'(data_o), 352'(exp_data));
        check({tag, "_valid_cnt"}, 352'(valid_cnt), 352'(exp_valid));
        check({tag, "_err_cnt"}, 352'(err_cnt), 352'(exp_err));
    endtask

    initial begin
        logic [255:0] ms_lit;
        logic [95:0]  data_lit;
        int           v0;

        tick(5);
        check("rst_ms", 352'(midstate_o), 352'(0));
        check("rst_data", 352'(data_o), 352'(0));
        check("rst_valid", 352'(work_valid_o), 352'(0));
        check("rst_err", 352'(frame_err_o), 352'(0));
        check("rst_busy", 352'(busy_o), 352'(0));
        rst_n = 1'b1;
        tick(20);

        // Counting pattern with random inter-byte idle.
        send_frame(0, 15);
        tick(2 * DIV);
        ms_lit   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        data_lit = 96'h202122232425262728292a2b;
        check("count_ms_lit", 352'(midstate_o), 352'(ms_lit));
        check("count_data_lit", 352'(data_o), 352'(data_lit));
        check_outputs("count");
        $display("txn count_frame valid=%0d", valid_cnt);

        // Bad stop bit on byte 10 discards the partial frame.
        for (int i = 0; i < 9; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, $urandom_range(0, 10));
        send_byte(8'h3C, 1'b0, 2 * DIV);
        check("err_busy", 352'(busy_o), 352'(0));
        check_outputs("err");
        send_frame(1, 8);
        tick(2 * DIV);
        check("a5_ms_lit", 352'(midstate_o), 352'({32{8'hA5}}));
        check("a5_data_lit", 352'(data_o), 352'({12{8'hA5}}));
        check_outputs("a5");
        $display("txn err_then_a5 err=%0d valid=%0d", err_cnt, valid_cnt);

        // Gap timeout drops 20 buffered bytes silently.
        for (int i = 0; i < 20; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, $urandom_range(0, 15));
        check("gap_busy_before", 352'(busy_o), 352'(1));
        tick(GAP + 50);
        q.delete();
        check("gap_busy_after", 352'(busy_o), 352'(0));
        send_frame(0, 15);
        tick(2 * DIV);
        check("gap_ms_lit", 352'(midstate_o), 352'(ms_lit));
        check_outputs("gap");
        $display("txn gap_then_count valid=%0d", valid_cnt);

        // Short low glitch must not start a byte.
        send_frame(2, 5);
        tick(2 * DIV);
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(3 * DIV);
        check("glitch_busy", 352'(busy_o), 352'(0));
        check_outputs("glitch");
        send_frame(2, 5);
        tick(2 * DIV);
        check_outputs("after_glitch");
        $display("txn glitch valid=%0d", valid_cnt);

        // Asynchronous reset mid byte 30.
        for (int i = 0; i < 29; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, $urandom_range(0, 5));
        rxd = 1'b0;
        tick(3 * DIV);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ms", 352'(midstate_o), 352'(0));
        check("arst_data", 352'(data_o), 352'(0));
        check("arst_busy", 352'(busy_o), 352'(0));
        q.delete();
        exp_ms = '0;
        exp_data = '0;
        rxd = 1'b1;
        tick(30);
        rst_n = 1'b1;
        tick(5);
        send_frame(2, 10);
        tick(2 * DIV);
        check_outputs("post_rst");
        $display("txn reset_mid_frame valid=%0d", valid_cnt);

        // Two frames with no idle between stop and next start.
        v0 = valid_cnt;
        send_frame(2, 0);
        send_frame(2, 0);
        tick(2 * DIV);
        check("b2b_pulses", 352'(valid_cnt - v0), 352'(2));
        check("b2b_spacing", 352'(last_valid_cyc - prev_valid_cyc), 352'(44 * 10 * DIV));
        check_outputs("b2b");
        check("pulse_width", 352'(wide_cnt), 352'(0));
        $display("txn back_to_back valid=%0d", valid_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_work_rx.md
# uart_work_rx

Serial work receiver for the miner: deserialises 8N1 UART bytes arriving from the AVR on the FPGA receive line. Assembles each 44-byte frame into a 256-bit midstate and a 96-bit data tail, then presents them with a one-cycle valid strobe to the hashing core. Sits directly upstream of the miner core, between the board-level top and the SHA-256 pipeline.

## Interface
- `CLK_HZ`, 50_000_000 — core clock frequency in Hz.
- `BAUD`, 115200 — serial bit rate.
- `GAP_CYCLES`, 5_000_000 — inter-byte idle limit that abandons a partial frame.
- `clk`  in  1 — core clock; the only clock.
- `rst_n`  in  1 — reset, asynchronous, active-low.
- `rxd`  in  1 — raw UART line from the AVR; asynchronous, idles high.
- `midstate_o`  out  256 — midstate of the last complete frame.
- `data_o`  out  96 — data tail (merkle/time/bits) of the last complete frame.
- `work_valid_o`  out  1 — one-cycle pulse; new work is on the outputs.
- `frame_err_o`  out  1 — one-cycle pulse; bad stop bit, frame discarded.
- `busy_o`  out  1 — high while a partial frame is buffered (byte count ≠ 0).

## Operation
- `rxd` passes through a 2-flop synchroniser; both flops reset to 1.
- `DIV = CLK_HZ/BAUD` is truncating integer division (434 at the defaults). `HALF = DIV/2`.
- The bit FSM has four states:
  - `IDLE`: on a synchronised falling edge, go to `START` with the bit counter loaded to `HALF-1`.
  - `START`: at the counter expiry, sample the line. If 1 (glitch), return to `IDLE` with nothing recorded. If 0, reload `DIV-1` and go to `DATA`.
  - `DATA`: sample 8 bits LSB-first at each `DIV` expiry, then go to `STOP`.
  - `STOP`: sample one bit. If 1, accept the byte. If 0, pulse `frame_err_o`, clear the byte count, and discard the partial frame. In both cases go to `IDLE`.
- Frame assembly:
  - Each accepted byte shifts into the low end of a 352-bit register: `frame = {frame[343:0], byte}`. The first byte received ends up as MSB `frame[351:344]`.
  - The 6-bit byte count increments per accepted byte.
  - On the 44th byte: `midstate_o <= frame[351:96]`, `data_o <= frame[95:0]` (including the new byte), pulse `work_valid_o`, and clear the count to 0.
- Gap timer:
  - Counts clk cycles while the count is ≠ 0 and the FSM is in `IDLE`.
  - Reaching `GAP_CYCLES` clears the count (no error pulse).
  - The timer resets on any falling edge.
- Outputs hold the last valid work until the next complete frame; a partial or errored frame never alters them.
- Reset values: `midstate_o`=0, `data_o`=0, `work_valid_o`=0, `frame_err_o`=0, `busy_o`=0, FSM=`IDLE`, count=0.

## Timing
- Sampling: mid-bit at `HALF`+k·`DIV` cycles after the synchronised falling edge. Synchroniser latency is 2 cycles.
- `work_valid_o`/`frame_err_o` are registered and assert on the clk edge following the stop-bit sample. Each is high for exactly one cycle.
- New outputs are valid in the same cycle `work_valid_o` is high.
- Back-to-back bytes: a start bit immediately after the stop sample (half-bit early) must be detected. `IDLE` is re-entered at the mid-stop point.
- Simultaneous events:
  - 44th byte accepted and gap expiry in the same cycle: the byte wins.
  - Gap expiry cannot coincide with a frame error, since the timer is idle outside `IDLE`.
- Reset asserted mid-frame clears all state immediately (async). Reception resumes at the first falling edge after `rst_n` rises.

## Structure
- Shared package `miner_pkg` holds:
  - `WORK_BYTES`=44, `MIDSTATE_W`=256, `DATA_W`=96, `FRAME_W`=352.
  - The FSM state enum for the bit receiver.
- Sub-module `uart_rx_byte` contains the synchroniser, bit FSM, and divider. It outputs `byte_o[7:0]`, `byte_stb_o`, `stop_err_o`, and `idle_o`.
- `uart_work_rx` itself holds the frame shift register, byte counter, gap timer, and output latches.

## Test plan
- 44 bytes 0x00..0x2B at 115200 baud:
  - Expect one `work_valid_o` pulse with `midstate_o`=256'h000102…1F and `data_o`=96'h202122…2B.
  - `busy_o` is high from byte 1 to byte 44.
- Byte 10 sent with stop bit 0:
  - Expect a `frame_err_o` pulse, no valid pulse, and `busy_o` low.
  - A following clean 44-byte frame of 0xA5 gives all-A5 outputs.
- 20 bytes, then line idle > `GAP_CYCLES`, then bytes 0x00..0x2B: expect one valid pulse carrying exactly the last 44 bytes.
- `rxd` low for 100 cycles then high (glitch shorter than `HALF`): expect no byte accepted, count stays 0, outputs unchanged.
- `rst_n` pulsed low during byte 30 of a frame:
  - Expect outputs to be 0 within the same cycle and `busy_o`=0.
  - A subsequent full frame is accepted correctly.
- Two frames sent back-to-back with no idle between stop and start bits: expect two valid pulses about 44·10·434 cycles apart, with the outputs equal to the second frame.
